// File: rtl/align_pkg.sv
// +--------------------------------------------------------------------+
// | align_pkg: shared widths, operand field offsets and slice helpers   |
// | for the align_4in mini-float aligner.                               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package align_pkg;

  localparam int EXP_WIDTH  = 4;
  localparam int SIG_WIDTH  = 4;
  localparam int LOW_EXPAND = 2;

  localparam int W   = SIG_WIDTH + 4 + LOW_EXPAND;
  localparam int OPW = 1 + EXP_WIDTH + SIG_WIDTH;

  // Operand layout is {sign, exp, man}, man at the bottom.
  localparam int MAN_LSB  = 0;
  localparam int EXP_LSB  = SIG_WIDTH;
  localparam int SIGN_BIT = SIG_WIDTH + EXP_WIDTH;

  function automatic logic [W-1:0] lane_slice(input logic [4*W-1:0] bus,
                                              input int unsigned     idx);
    return bus[idx*W +: W];
  endfunction

  function automatic logic [OPW-1:0] op_slice(input logic [4*OPW-1:0] bus,
                                              input int unsigned       idx);
    return bus[idx*OPW +: OPW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/align_lane.sv
// +--------------------------------------------------------------------+
// | align_lane: per-lane shift (stage 2) and negate (stage 3).          |
// | Optional: ALIGN4_ROUND_EN rounds half-up on the shifted magnitude.  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module align_lane
  import align_pkg::*;
#(
  parameter int expWidth   = EXP_WIDTH,
  parameter int sigWidth   = SIG_WIDTH,
  parameter int low_expand = LOW_EXPAND
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            adv_i,
  input  logic                            ld2_i,
  input  logic                            ld3_i,
  input  logic                            sign_i,
  input  logic [sigWidth:0]               sig_i,
  input  logic [expWidth-1:0]             dist_i,
  output logic [sigWidth+4+low_expand-1:0] lane_o
);

  localparam int LANE_W = sigWidth + 4 + low_expand;
  localparam int POS_W  = sigWidth + 1 + low_expand;
  localparam int EXT_W  = POS_W + 1;

  logic [EXT_W-1:0]  ext_w;
  logic [EXT_W-1:0]  shf_w;
  logic [LANE_W-1:0] mag_d;
  logic [LANE_W-1:0] mag_q;
  logic              sign_q;
  logic [LANE_W-1:0] lane_d;
  logic [LANE_W-1:0] lane_q;

  // One guard bit below the lane LSB captures the most significant discarded bit.
  always_comb begin
    ext_w = EXT_W'({sig_i, 1'b0}) << low_expand;
    shf_w = ext_w >> dist_i;
    mag_d = '0;
    if (int'(dist_i) < POS_W) begin
      mag_d = LANE_W'(shf_w[EXT_W-1:1]);
`ifdef ALIGN4_ROUND_EN
      mag_d = mag_d + LANE_W'(shf_w[0]);
`endif
    end
  end

  assign lane_d = sign_q ? (~mag_q + LANE_W'(1)) : mag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      lane_q <= '0;
    end else if (adv_i) begin
      if (ld2_i) begin
        mag_q  <= mag_d;
        sign_q <= sign_i;
      end
      if (ld3_i) begin
        lane_q <= lane_d;
      end
    end
  end

  assign lane_o = lane_q;

endmodule

`default_nettype wire

// File: rtl/align_4in.sv
// +--------------------------------------------------------------------+
// | align_4in: 3-stage four-operand mini-float aligner (max exp search, |
// | shift, negate). Optional: ALIGN4_ROUND_EN (round half-up).          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module align_4in
  import align_pkg::*;
#(
  parameter int expWidth   = EXP_WIDTH,
  parameter int sigWidth   = SIG_WIDTH,
  parameter int low_expand = LOW_EXPAND
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [4*(1+expWidth+sigWidth)-1:0]   operands,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [4*(sigWidth+4+low_expand)-1:0] manOffset,
  output logic [expWidth-1:0]                  maxExp
);

  localparam int LANE_W = sigWidth + 4 + low_expand;
  localparam int OP_W   = 1 + expWidth + sigWidth;

  logic                     adv;
  logic [3:0]               op_sign;
  logic [3:0][expWidth-1:0] op_exp;
  logic [3:0][sigWidth:0]   op_sig;
  logic [3:0][expWidth-1:0] op_dist;
  logic [expWidth-1:0]      max_d;

  logic                     s1_valid_q;
  logic                     s2_valid_q;
  logic                     s3_valid_q;
  logic [3:0]               s1_sign_q;
  logic [3:0][sigWidth:0]   s1_sig_q;
  logic [3:0][expWidth-1:0] s1_dist_q;
  logic [expWidth-1:0]      s1_max_q;
  logic [expWidth-1:0]      s2_max_q;
  logic [expWidth-1:0]      s3_max_q;
  logic [3:0][LANE_W-1:0]   lane_w;

  // A single advance enable keeps all stages in lockstep, bubbles included.
  assign adv       = ~s3_valid_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid_q;

  // Zero-exponent operands carry a zero significand and never win the max.
  always_comb begin
    max_d = '0;
    for (int i = 0; i < 4; i++) begin
      op_sign[i] = operands[i*OP_W + OP_W - 1];
      op_exp[i]  = operands[i*OP_W + sigWidth +: expWidth];
      op_sig[i]  = (op_exp[i] != '0) ? {1'b1, operands[i*OP_W +: sigWidth]} : '0;
      if (op_exp[i] > max_d) begin
        max_d = op_exp[i];
      end
    end
    for (int i = 0; i < 4; i++) begin
      op_dist[i] = max_d - op_exp[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      s1_sig_q   <= '0;
      s1_dist_q  <= '0;
      s1_max_q   <= '0;
      s2_max_q   <= '0;
      s3_max_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (in_valid) begin
        s1_sign_q <= op_sign;
        s1_sig_q  <= op_sig;
        s1_dist_q <= op_dist;
        s1_max_q  <= max_d;
      end
      if (s1_valid_q) begin
        s2_max_q <= s1_max_q;
      end
      if (s2_valid_q) begin
        s3_max_q <= s2_max_q;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    align_lane #(
      .expWidth   (expWidth),
      .sigWidth   (sigWidth),
      .low_expand (low_expand)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv_i  (adv),
      .ld2_i  (s1_valid_q),
      .ld3_i  (s2_valid_q),
      .sign_i (s1_sign_q[g]),
      .sig_i  (s1_sig_q[g]),
      .dist_i (s1_dist_q[g]),
      .lane_o (lane_w[g])
    );
  end

  // Output registers only ever hold valid bundles, but are masked while idle.
  always_comb begin
    manOffset = '0;
    maxExp    = '0;
    if (s3_valid_q) begin
      maxExp = s3_max_q;
      for (int i = 0; i < 4; i++) begin
        manOffset[i*LANE_W +: LANE_W] = lane_w[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_align_4in.sv
// +--------------------------------------------------------------------+
// | tb_align_4in: directed self-checking bench for align_4in.           |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_align_4in;
  import align_pkg::*;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [4*OPW-1:0]     operands  = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [4*W-1:0]       manOffset;
  logic [EXP_WIDTH-1:0] maxExp;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  align_4in dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operands  (operands),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .manOffset (manOffset),
    .maxExp    (maxExp)
  );

  function automatic logic [OPW-1:0] mk_op(input logic s, input logic [3:0] e, input logic [3:0] m);
    return {s, e, m};
  endfunction

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                           input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Stream bundle k: lane i has exp k+1, man k+i, positive -> lane value (16+k+i)*4.
  function automatic logic [4*OPW-1:0] stream_ops(input int k);
    logic [4*OPW-1:0] b;
    for (int i = 0; i < 4; i++) b[i*OPW +: OPW] = mk_op(1'b0, 4'(k + 1), 4'(k + i));
    return b;
  endfunction

  function automatic logic [4*W-1:0] stream_lanes(input int k);
    logic [4*W-1:0] b;
    for (int i = 0; i < 4; i++) b[i*W +: W] = W'((16 + k + i) * 4);
    return b;
  endfunction

  // Drives one bundle with out_ready high; lat counts cycles from accept to out_valid.
  task automatic run_bundle(input logic [4*OPW-1:0] ops, output int lat);
    int waitc;
    @(posedge clk); #1;
    operands = ops;
    in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = 99;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (manOffset !== '0) $display("FAIL reset_manOffset: got %h want 0", manOffset); else passed++;
    checks++; if (maxExp !== '0) $display("FAIL reset_maxExp: got %h want 0", maxExp); else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    int lat;
    run_bundle({4{mk_op(1'b0, 4'd5, 4'd0)}}, lat);
    checks++; if (lat !== 3) $display("FAIL basic_latency: got %0d want 3", lat); else passed++;
    checks++; if (manOffset !== pack4(10'h040, 10'h040, 10'h040, 10'h040))
      $display("FAIL basic_lanes: got %h want %h", manOffset, pack4(10'h040, 10'h040, 10'h040, 10'h040)); else passed++;
    checks++; if (maxExp !== 4'd5) $display("FAIL basic_maxExp: got %0d want 5", maxExp); else passed++;
  endtask

  task automatic test_negative();
    int lat;
    run_bundle({mk_op(1'b0, 4'd0, 4'd0), mk_op(1'b0, 4'd0, 4'd0),
                mk_op(1'b0, 4'd0, 4'd0), mk_op(1'b1, 4'd5, 4'd0)}, lat);
    checks++; if (lat !== 3) $display("FAIL neg_latency: got %0d want 3", lat); else passed++;
    checks++; if (manOffset !== pack4(10'h3C0, 10'h000, 10'h000, 10'h000))
      $display("FAIL neg_lanes: got %h want %h", manOffset, pack4(10'h3C0, 10'h000, 10'h000, 10'h000)); else passed++;
    checks++; if (maxExp !== 4'd5) $display("FAIL neg_maxExp: got %0d want 5", maxExp); else passed++;
  endtask

  task automatic test_mixed();
    int lat;
    // lane2 is a negative zero; lane3: 68>>1 = 34, negated = 0x3DE.
    run_bundle({mk_op(1'b1, 4'd4, 4'b0001), mk_op(1'b1, 4'd0, 4'b1111),
                mk_op(1'b0, 4'd3, 4'b1000), mk_op(1'b0, 4'd5, 4'd0)}, lat);
    checks++; if (manOffset !== pack4(10'h040, 10'h018, 10'h000, 10'h3DE))
      $display("FAIL mixed_lanes: got %h want %h", manOffset, pack4(10'h040, 10'h018, 10'h000, 10'h3DE)); else passed++;
    checks++; if (maxExp !== 4'd5) $display("FAIL mixed_maxExp: got %0d want 5", maxExp); else passed++;
  endtask

  task automatic test_far_shift();
    int lat;
    logic [W-1:0] l2;
`ifdef ALIGN4_ROUND_EN
    l2 = 10'd2;
`else
    l2 = 10'd1;
`endif
    // d=7 on lane1 flushes to zero; d=6 on lane2 leaves 124>>6.
    run_bundle({mk_op(1'b1, 4'd8, 4'b1111), mk_op(1'b0, 4'd2, 4'b1111),
                mk_op(1'b0, 4'd1, 4'b1111), mk_op(1'b0, 4'd8, 4'd0)}, lat);
    checks++; if (manOffset !== pack4(10'h040, 10'h000, l2, 10'h384))
      $display("FAIL far_lanes: got %h want %h", manOffset, pack4(10'h040, 10'h000, l2, 10'h384)); else passed++;
    checks++; if (maxExp !== 4'd8) $display("FAIL far_maxExp: got %0d want 8", maxExp); else passed++;
  endtask

  task automatic test_round();
    int lat;
    logic [W-1:0] l1;
`ifdef ALIGN4_ROUND_EN
    l1 = 10'd6;
`else
    l1 = 10'd5;
`endif
    run_bundle({mk_op(1'b0, 4'd0, 4'd0), mk_op(1'b0, 4'd0, 4'd0),
                mk_op(1'b0, 4'd2, 4'b0110), mk_op(1'b0, 4'd6, 4'd0)}, lat);
    checks++; if (lane_slice(manOffset, 1) !== l1)
      $display("FAIL round_lane1: got %0d want %0d", lane_slice(manOffset, 1), l1); else passed++;
    checks++; if (manOffset !== pack4(10'h040, l1, 10'h000, 10'h000))
      $display("FAIL round_lanes: got %h want %h", manOffset, pack4(10'h040, l1, 10'h000, 10'h000)); else passed++;
    checks++; if (maxExp !== 4'd6) $display("FAIL round_maxExp: got %0d want 6", maxExp); else passed++;
  endtask

  task automatic test_all_zero();
    int lat;
    run_bundle({4{mk_op(1'b1, 4'd0, 4'b1010)}}, lat);
    checks++; if (lat !== 3) $display("FAIL zero_latency: got %0d want 3", lat); else passed++;
    checks++; if (manOffset !== '0) $display("FAIL zero_lanes: got %h want 0", manOffset); else passed++;
    checks++; if (maxExp !== 4'd0) $display("FAIL zero_maxExp: got %0d want 0", maxExp); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    logic held = 1'b0;
    logic [4*W-1:0] held_lanes = '0;
    logic [EXP_WIDTH-1:0] held_max = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = (sent < 6);
      operands  = stream_ops(sent < 6 ? sent : 0);
      #1;
      if (out_valid) begin
        if (held) begin
          checks++; if (manOffset !== held_lanes || maxExp !== held_max)
            $display("FAIL stall_stable: got %h/%0d want %h/%0d", manOffset, maxExp, held_lanes, held_max); else passed++;
        end
        if (!out_ready) begin
          checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready); else passed++;
          held = 1'b1;
          held_lanes = manOffset;
          held_max = maxExp;
        end else begin
          held = 1'b0;
          if (recv >= 6) begin
            checks++;
            $display("FAIL stream_extra: got bundle %0d want none", recv);
          end else begin
            checks++; if (manOffset !== stream_lanes(recv) || maxExp !== 4'(recv + 1))
              $display("FAIL stream_data%0d: got %h/%0d want %h/%0d", recv, manOffset, maxExp,
                       stream_lanes(recv), recv + 1); else passed++;
          end
          recv++;
        end
      end else begin
        held = 1'b0;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (recv !== 6) $display("FAIL stream_count: got %0d want 6", recv); else passed++;
  endtask

  task automatic test_reset_inflight();
    int lat;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      operands = stream_ops(k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (manOffset !== '0) $display("FAIL rstmid_manOffset: got %h want 0", manOffset); else passed++;
    checks++; if (maxExp !== '0) $display("FAIL rstmid_maxExp: got %0d want 0", maxExp); else passed++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rstmid_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
    run_bundle({mk_op(1'b0, 4'd0, 4'd0), mk_op(1'b0, 4'd0, 4'd0),
                mk_op(1'b0, 4'd3, 4'b1000), mk_op(1'b0, 4'd5, 4'd0)}, lat);
    checks++; if (lat !== 3) $display("FAIL rstmid_latency: got %0d want 3", lat); else passed++;
    checks++; if (manOffset !== pack4(10'h040, 10'h018, 10'h000, 10'h000) || maxExp !== 4'd5)
      $display("FAIL rstmid_data: got %h/%0d want %h/5", manOffset, maxExp,
               pack4(10'h040, 10'h018, 10'h000, 10'h000)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_mixed();
    test_far_shift();
    test_round();
    test_all_zero();
    test_back_to_back();
    test_reset_inflight();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
